autosa_dbb_axi_responder: RTL

- AXI4 slave model that responds to the autosa dbb/cvsram master ports; 256-bit data path, 8-bit IDs, 4-bit INCR lengths, fixed 32-byte beats.
- Backs a beat-addressed SRAM array used as system memory in the large-config testbench and FPGA shell.
- Read and write channels are handled by two independent FSMs that share one memory array.
- Single outstanding burst per direction.

---
 rtl/autosa_dbb_pkg.sv | 19 +
 rtl/autosa_dbb_axi_responder_if.sv | 64 ++++++
 rtl/autosa_dbb_beat_mem.sv | 33 +++
 rtl/autosa_dbb_axi_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/autosa_dbb_pkg.sv
// Shared types and constants for the autosa dbb/cvsram AXI4 responder.
package autosa_dbb_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    localparam int         BEAT_BYTES = 32;
    localparam logic [2:0] AXSIZE_32B = 3'b101;
    localparam logic [7:0] LFSR_SEED  = 8'hA5;

endpackage

// File: rtl/autosa_dbb_axi_responder_if.sv
// AXI4 bus bundle between the autosa dbb master and the memory responder.
interface autosa_dbb_axi_responder_if #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 64,
    parameter int ID_W   = 8
) ();

    logic                aw_awvalid;
    logic                aw_awready;
    logic [ID_W-1:0]     aw_awid;
    logic [3:0]          aw_awlen;
    logic [2:0]          aw_awsize;
    logic [ADDR_W-1:0]   aw_awaddr;

    logic                w_wvalid;
    logic                w_wready;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W/8-1:0] w_wstrb;
    logic                w_wlast;

    logic                b_bvalid;
    logic                b_bready;
    logic [ID_W-1:0]     b_bid;

    logic                ar_arvalid;
    logic                ar_arready;
    logic [ID_W-1:0]     ar_arid;
    logic [3:0]          ar_arlen;
    logic [2:0]          ar_arsize;
    logic [ADDR_W-1:0]   ar_araddr;

    logic                r_rvalid;
    logic                r_rready;
    logic [ID_W-1:0]     r_rid;
    logic                r_rlast;
    logic [DATA_W-1:0]   r_rdata;

    modport slave (
        input  aw_awvalid, aw_awid, aw_awlen, aw_awsize, aw_awaddr,
        output aw_awready,
        input  w_wvalid, w_wdata, w_wstrb, w_wlast,
        output w_wready,
        output b_bvalid, b_bid,
        input  b_bready,
        input  ar_arvalid, ar_arid, ar_arlen, ar_arsize, ar_araddr,
        output ar_arready,
        output r_rvalid, r_rid, r_rlast, r_rdata,
        input  r_rready
    );

    modport master (
        output aw_awvalid, aw_awid, aw_awlen, aw_awsize, aw_awaddr,
        input  aw_awready,
        output w_wvalid, w_wdata, w_wstrb, w_wlast,
        input  w_wready,
        input  b_bvalid, b_bid,
        output b_bready,
        output ar_arvalid, ar_arid, ar_arlen, ar_arsize, ar_araddr,
        input  ar_arready,
        input  r_rvalid, r_rid, r_rlast, r_rdata,
        output r_rready
    );

endinterface

// File: rtl/autosa_dbb_beat_mem.sv
// Beat-addressed storage: one byte-enabled write port, one asynchronous read port.
// Contents are deliberately not reset so system memory survives an rstn pulse.
module autosa_dbb_beat_mem #(
    parameter int DATA_W    = 256,
    parameter int MEM_DEPTH = 1024,
    localparam int IDX_W    = $clog2(MEM_DEPTH),
    localparam int STRB_W   = DATA_W / 8
) (
    input  logic              core_clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Byte-masked write of one beat
    always_ff @(posedge core_clk) begin
        if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/autosa_dbb_axi_responder.sv
// AXI4 slave memory model for the autosa dbb/cvsram master ports.
// Independent read and write FSMs share one beat memory; one burst in flight per direction.
// Optional macro AUTOSA_DBB_RESP_STALL_EN adds LFSR-driven random stalls on the ready signals.
module autosa_dbb_axi_responder
    import autosa_dbb_pkg::*;
#(
    parameter int DATA_W    = 256,
    parameter int ADDR_W    = 64,
    parameter int ID_W      = 8,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                        core_clk,
    input  logic                        rstn,
    autosa_dbb_axi_responder_if.slave   bus,
    output logic                        prot_err
);

    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int OFF_W  = $clog2(BEAT_BYTES);
    localparam int STRB_W = DATA_W / 8;

    typedef logic [IDX_W-1:0] idx_t;
    localparam idx_t IDX_ONE = idx_t'(1);

    w_state_t          w_state;
    logic              awready_q, wready_q, bvalid_q;
    logic [ID_W-1:0]   bid_q;
    idx_t              w_idx;
    logic [3:0]        w_len, w_cnt;

    r_state_t          r_state;
    logic              arready_q, rvalid_q, rlast_q;
    logic [ID_W-1:0]   rid_q;
    logic [DATA_W-1:0] rdata_q;
    idx_t              r_idx;
    logic [3:0]        r_len, r_cnt;

    logic              stall;
    logic              aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic              w_is_last;
    idx_t              aw_idx, ar_idx, mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic              unused_addr_bits;

`ifdef AUTOSA_DBB_RESP_STALL_EN
    logic [7:0] lfsr;

    // Free-running Fibonacci LFSR (taps 8,6,5,4) that injects ready stalls
    always_ff @(posedge core_clk or negedge rstn) begin
        if (!rstn) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    assign bus.aw_awready = awready_q & ~stall;
    assign bus.w_wready   = wready_q  & ~stall;
    assign bus.ar_arready = arready_q & ~stall;
    assign bus.b_bvalid   = bvalid_q;
    assign bus.b_bid      = bid_q;
    assign bus.r_rvalid   = rvalid_q;
    assign bus.r_rlast    = rlast_q;
    assign bus.r_rid      = rid_q;
    assign bus.r_rdata    = rdata_q;

    assign aw_fire   = bus.aw_awvalid & bus.aw_awready;
    assign w_fire    = bus.w_wvalid   & bus.w_wready;
    assign b_fire    = bvalid_q       & bus.b_bready;
    assign ar_fire   = bus.ar_arvalid & bus.ar_arready;
    assign r_fire    = rvalid_q       & bus.r_rready;
    assign w_is_last = (w_cnt == w_len);

    assign aw_idx = bus.aw_awaddr[IDX_W+OFF_W-1:OFF_W];
    assign ar_idx = bus.ar_araddr[IDX_W+OFF_W-1:OFF_W];

    assign unused_addr_bits = ^{bus.aw_awaddr[ADDR_W-1:IDX_W+OFF_W], bus.aw_awaddr[OFF_W-1:0],
                                bus.ar_araddr[ADDR_W-1:IDX_W+OFF_W], bus.ar_araddr[OFF_W-1:0]};

    // Read port points at the burst's first beat while idle, else at the beat after the one on the bus
    always_comb begin
        mem_raddr = ar_idx;
        if (r_state == R_DATA) begin
            mem_raddr = r_idx + IDX_ONE;
        end
    end

    autosa_dbb_beat_mem #(
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .core_clk (core_clk),
        .we       (w_fire),
        .waddr    (w_idx),
        .wdata    (bus.w_wdata),
        .wstrb    (bus.w_wstrb[STRB_W-1:0]),
        .raddr    (mem_raddr),
        .rdata    (mem_rdata)
    );

    // Write channel FSM: accept address, collect beats, then hold the response until taken
    always_ff @(posedge core_clk or negedge rstn) begin
        if (!rstn) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            w_idx     <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_fire) begin
                        bid_q     <= bus.aw_awid;
                        w_len     <= bus.aw_awlen;
                        w_idx     <= aw_idx;
                        w_cnt     <= '0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_idx <= w_idx + IDX_ONE;
                        w_cnt <= w_cnt + 4'd1;
                        if (w_is_last) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            w_state  <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_fire) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM: preload the first beat on AR, refill rdata only when a beat is taken
    always_ff @(posedge core_clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            r_idx     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        rid_q     <= bus.ar_arid;
                        r_len     <= bus.ar_arlen;
                        r_cnt     <= '0;
                        r_idx     <= ar_idx;
                        rdata_q   <= mem_rdata;
                        rvalid_q  <= 1'b1;
                        rlast_q   <= (bus.ar_arlen == 4'd0);
                        arready_q <= 1'b0;
                        r_state   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            r_state   <= R_IDLE;
                        end else begin
                            r_idx   <= r_idx + IDX_ONE;
                            r_cnt   <= r_cnt + 4'd1;
                            rdata_q <= mem_rdata;
                            rlast_q <= ((r_cnt + 4'd1) == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Sticky protocol-error flag for bad beat sizes and misplaced wlast
    always_ff @(posedge core_clk or negedge rstn) begin
        if (!rstn) begin
            prot_err <= 1'b0;
        end else if ((aw_fire && (bus.aw_awsize != AXSIZE_32B)) ||
                     (ar_fire && (bus.ar_arsize != AXSIZE_32B)) ||
                     (w_fire  && (bus.w_wlast != w_is_last))) begin
            prot_err <= 1'b1;
        end
    end

endmodule
